fpu_issue_ctrl: RTL

Upstream issue stage for the 64-bit `fpu`. It accepts operations from a producer over a valid/ready handshake and buffers them in an input FIFO. It issues them to the non-stallable FPU under a credit scheme that guarantees every result a slot. It then captures each result and its flags after a fixed latency into a tagged result FIFO, which drains through a valid/ready handshake. Between issues the FPU operand registers hold their previous values, so idle cycles add no operand toggles to power measurements.

---
 rtl/fpu_issue_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/fpu_issue_ctrl.sv
// Issue stage for the 64-bit fpu: input FIFO, credit-gated issue into a
// fixed-latency pipeline, and a tagged result FIFO drained by the consumer.
module fpu_issue_ctrl #(
    parameter int LATENCY   = 4,
    parameter int IN_DEPTH  = 4,
    parameter int RES_DEPTH = 8,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst,

    // valid/ready: a transfer occurs on a rising edge where both are high;
    // the source holds valid and payload stable until that edge.
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_a,
    input  logic [63:0]      in_b,
    input  logic [2:0]       in_op,
    input  logic [1:0]       in_rmode,
    input  logic [TAG_W-1:0] in_tag,

    output logic [63:0]      fpu_a,
    output logic [63:0]      fpu_b,
    output logic [2:0]       fpu_op,
    output logic [1:0]       fpu_rmode,
    input  logic [63:0]      fpu_out,
    input  logic [7:0]       fpu_flags,

    output logic             res_valid,
    input  logic             res_ready,
    output logic [63:0]      res_data,
    output logic [7:0]       res_flags,
    output logic [TAG_W-1:0] res_tag,

    output logic             busy,
    output logic [31:0]      issued_count
);

    localparam int IAW = $clog2(IN_DEPTH);
    localparam int RAW = $clog2(RES_DEPTH);
    localparam int CW  = RAW + 2;

    typedef struct packed {
        logic [63:0]      a;
        logic [63:0]      b;
        logic [2:0]       op;
        logic [1:0]       rmode;
        logic [TAG_W-1:0] tag;
    } op_t;

    typedef struct packed {
        logic [63:0]      data;
        logic [7:0]       flags;
        logic [TAG_W-1:0] tag;
    } res_t;

    // ---------------- input FIFO ----------------
    op_t          in_mem [IN_DEPTH];
    logic [IAW:0] in_wr_ptr;
    logic [IAW:0] in_rd_ptr;
    logic [IAW:0] in_cnt;
    logic         in_empty;
    logic         in_full;
    logic         in_push;
    op_t          in_head;

    assign in_cnt   = in_wr_ptr - in_rd_ptr;
    assign in_empty = (in_cnt == '0);
    assign in_full  = (in_cnt == (IAW+1)'(IN_DEPTH));
    assign in_ready = !in_full;
    assign in_push  = in_valid && in_ready;
    assign in_head  = in_mem[in_rd_ptr[IAW-1:0]];

    always_ff @(posedge clk) begin
        if (in_push) begin
            in_mem[in_wr_ptr[IAW-1:0]] <= {in_a, in_b, in_op, in_rmode, in_tag};
        end
    end

    // ---------------- credit and issue ----------------
    logic [CW-1:0] inflight_cnt;
    logic [CW-1:0] outstanding;
    logic [RAW:0]  res_cnt;
    logic          credit_ok;
    logic          issue;
    logic          capture;

    // Every issued op owns a result slot until it is popped, so capture
    // can never meet a full result FIFO.
    assign outstanding = inflight_cnt + CW'(res_cnt);
    assign credit_ok   = (outstanding < CW'(RES_DEPTH));
    assign issue       = !in_empty && credit_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_wr_ptr <= '0;
            in_rd_ptr <= '0;
        end else begin
            if (in_push) in_wr_ptr <= in_wr_ptr + (IAW+1)'(1);
            if (issue)   in_rd_ptr <= in_rd_ptr + (IAW+1)'(1);
        end
    end

    // Operand registers only move on issue to keep idle cycles toggle-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpu_a     <= '0;
            fpu_b     <= '0;
            fpu_op    <= '0;
            fpu_rmode <= '0;
        end else if (issue) begin
            fpu_a     <= in_head.a;
            fpu_b     <= in_head.b;
            fpu_op    <= in_head.op;
            fpu_rmode <= in_head.rmode;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued_count <= '0;
        end else if (issue) begin
            issued_count <= issued_count + 32'd1;
        end
    end

    // ---------------- latency pipeline ----------------
    logic [LATENCY-1:0] pipe_valid;
    logic [TAG_W-1:0]   pipe_tag [LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_tag[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= issue;
            pipe_tag[0]   <= in_head.tag;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_tag[i]   <= pipe_tag[i-1];
            end
        end
    end

    assign capture = pipe_valid[LATENCY-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_cnt <= '0;
        end else begin
            case ({issue, capture})
                2'b10:   inflight_cnt <= inflight_cnt + CW'(1);
                2'b01:   inflight_cnt <= inflight_cnt - CW'(1);
                default: inflight_cnt <= inflight_cnt;
            endcase
        end
    end

    // ---------------- result FIFO ----------------
    res_t         res_mem [RES_DEPTH];
    logic [RAW:0] res_wr_ptr;
    logic [RAW:0] res_rd_ptr;
    logic         res_empty;
    logic         res_pop;
    res_t         res_head;

    assign res_cnt   = res_wr_ptr - res_rd_ptr;
    assign res_empty = (res_cnt == '0);
    assign res_valid = !res_empty;
    assign res_pop   = res_valid && res_ready;
    assign res_head  = res_mem[res_rd_ptr[RAW-1:0]];

    always_ff @(posedge clk) begin
        if (capture) begin
            res_mem[res_wr_ptr[RAW-1:0]] <= {fpu_out, fpu_flags, pipe_tag[LATENCY-1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_wr_ptr <= '0;
            res_rd_ptr <= '0;
        end else begin
            if (capture) res_wr_ptr <= res_wr_ptr + (RAW+1)'(1);
            if (res_pop) res_rd_ptr <= res_rd_ptr + (RAW+1)'(1);
        end
    end

    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign res_data  = res_valid ? res_head.data  : '0;
    assign res_flags = res_valid ? res_head.flags : '0;
    assign res_tag   = res_valid ? res_head.tag   : '0;

    assign busy = !in_empty || (inflight_cnt != '0) || res_valid;

endmodule
